// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared CDB tag/data widths and the broadcast entry type
package cdb_pkg;

    localparam int LABEL_W = 5;
    localparam int DATA_W  = 32;

    // Tag 0 means "no pending producer" and is never broadcast.
    localparam logic [LABEL_W-1:0] NO_LABEL = '0;

    typedef struct packed {
        logic [LABEL_W-1:0] label;
        logic [DATA_W-1:0]  data;
    } cdb_entry;

endpackage

// File: rtl/cdb_src_fifo.sv
// rtl/cdb_src_fifo.sv - per-source result FIFO with push/pop/flush and registered head
module cdb_src_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // DEPTH is a power of two, so the count MSB alone marks a full FIFO.
    assign full    = count_q[AW];
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// rtl/cdb_broadcaster.sv - CDB producer: per-source FIFOs, round-robin pick, registered broadcast (CDB_PERF_EN adds perf counters)
module cdb_broadcaster #(
    parameter int N_SRC      = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int LABEL_W    = cdb_pkg::LABEL_W,
    parameter int DATA_W     = cdb_pkg::DATA_W
) (
    input  logic                       clk,
    input  logic                       nRST,
    input  logic                       flush,
    input  logic [N_SRC-1:0]           src_valid,
    input  logic [N_SRC*LABEL_W-1:0]   src_label,
    input  logic [N_SRC*DATA_W-1:0]    src_data,
    output logic [N_SRC-1:0]           src_ready,
    output logic                       bc_en,
    output logic [LABEL_W-1:0]         bc_label,
    output logic [DATA_W-1:0]          bc_data,
`ifdef CDB_PERF_EN
    output logic [31:0]                perf_bc_cnt,
    output logic [31:0]                perf_conflict_cnt,
`endif
    output logic                       drop_err
);
    import cdb_pkg::*;

    localparam int EW = LABEL_W + DATA_W;
    localparam int PW = $clog2(N_SRC);

    logic [N_SRC-1:0] push, pop, full, empty, label_zero;
    logic [EW-1:0]    head [N_SRC];

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        assign label_zero[i] = (src_label[i*LABEL_W +: LABEL_W] == LABEL_W'(NO_LABEL));
        assign src_ready[i]  = ~full[i];
        assign push[i]       = src_valid[i] & ~full[i] & ~label_zero[i];

        cdb_src_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (EW)
        ) u_fifo (
            .clk   (clk),
            .nRST  (nRST),
            .flush (flush),
            .push  (push[i]),
            .pop   (pop[i]),
            .wdata ({src_label[i*LABEL_W +: LABEL_W], src_data[i*DATA_W +: DATA_W]}),
            .full  (full[i]),
            .empty (empty[i]),
            .head  (head[i])
        );
    end

    logic               bc_en_q, bc_en_d;
    logic [LABEL_W-1:0] bc_label_q, bc_label_d;
    logic [DATA_W-1:0]  bc_data_q, bc_data_d;
    logic               drop_err_q, drop_err_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               found;
    logic [PW-1:0]      win, cand;
    int                 idx;

    // Scan from rr_ptr with wrap; the first non-empty FIFO wins.
    always_comb begin
        found = 1'b0;
        win   = rr_ptr_q;
        idx   = 0;
        cand  = '0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_SRC) begin
                idx = idx - N_SRC;
            end
            cand = PW'(idx);
            if (!found && !empty[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        pop        = '0;
        bc_en_d    = 1'b0;
        bc_label_d = '0;
        bc_data_d  = '0;
        rr_ptr_d   = rr_ptr_q;
        drop_err_d = |(src_valid & label_zero) & ~flush;
        if (found && !flush) begin
            pop[win]                 = 1'b1;
            bc_en_d                  = 1'b1;
            {bc_label_d, bc_data_d}  = head[win];
            rr_ptr_d                 = (win == PW'(N_SRC - 1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            bc_en_q    <= 1'b0;
            bc_label_q <= '0;
            bc_data_q  <= '0;
            drop_err_q <= 1'b0;
            rr_ptr_q   <= '0;
        end else begin
            bc_en_q    <= bc_en_d;
            bc_label_q <= bc_label_d;
            bc_data_q  <= bc_data_d;
            drop_err_q <= drop_err_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign bc_en    = bc_en_q;
    assign bc_label = bc_label_q;
    assign bc_data  = bc_data_q;
    assign drop_err = drop_err_q;

`ifdef CDB_PERF_EN
    logic [31:0]      perf_bc_q, perf_bc_d;
    logic [31:0]      perf_cf_q, perf_cf_d;
    logic [N_SRC-1:0] non_empty;

    assign non_empty = ~empty;

    // More than one bit set means a real arbitration conflict; flush does not clear these.
    always_comb begin
        perf_bc_d = perf_bc_q + {31'd0, bc_en_d};
        perf_cf_d = perf_cf_q;
        if (!flush && (|(non_empty & (non_empty - 1'b1)))) begin
            perf_cf_d = perf_cf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            perf_bc_q <= '0;
            perf_cf_q <= '0;
        end else begin
            perf_bc_q <= perf_bc_d;
            perf_cf_q <= perf_cf_d;
        end
    end

    assign perf_bc_cnt       = perf_bc_q;
    assign perf_conflict_cnt = perf_cf_q;
`endif

endmodule

// File: tb/tb_cdb_broadcaster.sv
// tb/tb_cdb_broadcaster.sv - scoreboard bench for cdb_broadcaster
module tb_cdb_broadcaster;
    localparam int N  = 4;
    localparam int LW = 5;
    localparam int DW = 32;

    typedef struct packed {
        logic [LW-1:0] label;
        logic [DW-1:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            nRST = 1'b0;
    logic            flush = 1'b0;
    logic [N-1:0]    src_valid = '0;
    logic [N*LW-1:0] src_label = '0;
    logic [N*DW-1:0] src_data = '0;
    logic [N-1:0]    src_ready;
    logic            bc_en;
    logic [LW-1:0]   bc_label;
    logic [DW-1:0]   bc_data;
    logic            drop_err;
`ifdef CDB_PERF_EN
    logic [31:0]     perf_bc_cnt;
    logic [31:0]     perf_conflict_cnt;
`endif

    always #5 clk = ~clk;

    cdb_broadcaster dut (
        .clk               (clk),
        .nRST              (nRST),
        .flush             (flush),
        .src_valid         (src_valid),
        .src_label         (src_label),
        .src_data          (src_data),
        .src_ready         (src_ready),
        .bc_en             (bc_en),
        .bc_label          (bc_label),
        .bc_data           (bc_data),
`ifdef CDB_PERF_EN
        .perf_bc_cnt       (perf_bc_cnt),
        .perf_conflict_cnt (perf_conflict_cnt),
`endif
        .drop_err          (drop_err)
    );

    int   checks = 0;
    int   failures = 0;
    int   bc_seen = 0;
    bit   per_src = 1'b0;
    exp_t exp_q[$];
    exp_t src_q[N][$];
    int   nxt[N];
    int   lim[N];
    logic acc[N];
    int   acc_cnt;
    int   cnt3;
    int   base;
    int   waited;
    logic pop3;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [LW-1:0] l, input logic [DW-1:0] d);
        return {l, d};
    endfunction

    function automatic int pending();
        int n = exp_q.size();
        for (int i = 0; i < N; i++) n += src_q[i].size();
        return n;
    endfunction

    task automatic set_src(input int i, input logic v, input logic [LW-1:0] l, input logic [DW-1:0] d);
        src_valid[i]         = v;
        src_label[i*LW +: LW] = l;
        src_data[i*DW +: DW]  = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (pending() > 0 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (pending() > 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", pending());
        end
        repeat (3) step();
    endtask

    // Monitor: every broadcast must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        int   s;
        if (nRST && bc_en) begin
            bc_seen++;
            if (per_src) begin
                s = int'(bc_label[1:0]);
                if (src_q[s].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_bc actual=%0d required=none", bc_label);
                end else begin
                    e = src_q[s].pop_front();
                    check("bc_src_entry", 64'({bc_label, bc_data}), 64'(e));
                end
            end else begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_bc actual=%0d required=none", bc_label);
                end else begin
                    e = exp_q.pop_front();
                    check("bc_entry", 64'({bc_label, bc_data}), 64'(e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst_bc_en", 64'(bc_en), 64'd0);
        check("rst_bc_label", 64'(bc_label), 64'd0);
        check("rst_bc_data", 64'(bc_data), 64'd0);
        check("rst_drop_err", 64'(drop_err), 64'd0);
        check("rst_src_ready", 64'(src_ready), 64'hF);
        @(negedge clk);
        nRST = 1'b1;
        step();

        // Contention: all four push at once, rr_ptr=0 -> 1,2,3,4
        for (int i = 0; i < N; i++) begin
            set_src(i, 1'b1, LW'(i + 1), 32'hC000_0000 + DW'(i + 1));
            exp_q.push_back(mk(LW'(i + 1), 32'hC000_0000 + DW'(i + 1)));
        end
        step();
        src_valid = '0;
        drain();

        // Single result from src1; rr_ptr back at 0
        set_src(1, 1'b1, 5'd5, 32'hDEADBEEF);
        exp_q.push_back(mk(5'd5, 32'hDEADBEEF));
        step();
        src_valid = '0;
        @(negedge clk);
        check("no_bypass", 64'(bc_en), 64'd0);
        @(negedge clk);
        check("single_bc_en", 64'(bc_en), 64'd1);
        check("single_label", 64'(bc_label), 64'd5);
        @(negedge clk);
        check("single_one_cycle", 64'(bc_en), 64'd0);
        step();
        drain();

        // Fairness: src0=7, src2=9 held valid for 8 edges, rr_ptr=2 -> 9,7 x5
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(mk(5'd9, 32'h9));
            exp_q.push_back(mk(5'd7, 32'h7));
        end
        set_src(0, 1'b1, 5'd7, 32'h7);
        set_src(2, 1'b1, 5'd9, 32'h9);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("fair_ready3", 64'(src_ready[3]), 64'd1);
            step();
        end
        src_valid = '0;
        drain();

        // Label 0 from src2
        set_src(2, 1'b1, 5'd0, 32'h1234_5678);
        step();
        src_valid = '0;
        @(negedge clk);
        check("drop_err_pulse", 64'(drop_err), 64'd1);
        @(negedge clk);
        check("drop_err_clear", 64'(drop_err), 64'd0);
        check("drop_no_bc", 64'(bc_en), 64'd0);
        check("drop_ready", 64'(src_ready), 64'hF);
        step();

        // Flush with 3 entries pending
        set_src(0, 1'b1, 5'd11, 32'hF0);
        set_src(1, 1'b1, 5'd12, 32'hF1);
        set_src(2, 1'b1, 5'd13, 32'hF2);
        step();
        src_valid = '0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("flush_bc_en", 64'(bc_en), 64'd0);
            check("flush_ready", 64'(src_ready), 64'hF);
        end
        step();

        // Backpressure: src0-2 six entries each, src3 four back-to-back
        per_src = 1'b1;
        lim[0] = 6; lim[1] = 6; lim[2] = 6; lim[3] = 4;
        for (int i = 0; i < N; i++) begin
            nxt[i] = 1;
            for (int j = 1; j <= lim[i]; j++) begin
                src_q[i].push_back(mk(LW'(j * 4 + i), 32'hB000_0000 + DW'(j * 4 + i)));
            end
        end
        acc_cnt = 0;
        cnt3 = 0;
        base = bc_seen;
        for (int cyc = 0; cyc < 60; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (nxt[i] <= lim[i]) begin
                    set_src(i, 1'b1, LW'(nxt[i] * 4 + i), 32'hB000_0000 + DW'(nxt[i] * 4 + i));
                end else begin
                    set_src(i, 1'b0, '0, '0);
                end
            end
            @(negedge clk);
            check("bp_ready3", 64'(src_ready[3]), 64'(cnt3 < 2));
            for (int i = 0; i < N; i++) acc[i] = src_valid[i] & src_ready[i];
            step();
            pop3 = bc_en && (bc_label[1:0] == 2'd3);
            cnt3 = cnt3 + int'(acc[3]) - int'(pop3);
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    nxt[i]++;
                    acc_cnt++;
                end
            end
        end
        src_valid = '0;
        drain();
        check("bp_accepted", 64'(acc_cnt), 64'd22);
        check("bp_conservation", 64'(bc_seen - base), 64'(acc_cnt));

        // Reset mid-traffic
        for (int i = 0; i < N; i++) begin
            set_src(i, 1'b1, LW'(28 + i), 32'hA000_0000 + DW'(i));
            src_q[i].push_back(mk(LW'(28 + i), 32'hA000_0000 + DW'(i)));
        end
        step();
        src_valid = '0;
        waited = 0;
        while (!bc_en && waited < 5) begin
            @(negedge clk);
            waited++;
        end
        check("rst_mid_bc_seen", 64'(bc_en), 64'd1);
        @(posedge clk);
        #3;
        nRST = 1'b0;
        #1;
        check("rst_mid_bc_en", 64'(bc_en), 64'd0);
        check("rst_mid_bc_label", 64'(bc_label), 64'd0);
        check("rst_mid_bc_data", 64'(bc_data), 64'd0);
        for (int i = 0; i < N; i++) src_q[i].delete();
        @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", 64'(src_ready), 64'hF);
        check("rst_mid_idle", 64'(bc_en), 64'd0);
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
